// File: rtl/binary_tree_sched_pkg.sv
// Shared state encoding and width helpers for the binary tree adder scheduler.
package binary_tree_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } sched_state_e;

   // Requester id width; a single requester still gets a 1-bit id.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int tree_sum_width(input int p, input int n);
      return p + $clog2(n);
   endfunction

endpackage

// File: rtl/binary_tree_adder.sv
// Combinational binary reduction tree over INPUTS_AMOUNT P-bit elements, signed or unsigned.
module binary_tree_adder
   import binary_tree_sched_pkg::*;
#(
   parameter int INPUTS_AMOUNT = 8,
   parameter int P             = 8,
   parameter int MODE          = 1,
   localparam int SUM_W        = tree_sum_width(P, INPUTS_AMOUNT)
) (
   input  logic [INPUTS_AMOUNT*P-1:0] data_i,
   input  logic                       signed_i,
   output logic [SUM_W-1:0]           sum_o
);

   if (MODE != 1) begin : g_mode_chk
      $error("binary_tree_adder: only the combinational MODE=1 is provided");
   end

   // Heap layout: node i has children 2i+1 and 2i+2, leaves occupy the top half.
   always_comb begin
      logic [SUM_W-1:0] node [2*INPUTS_AMOUNT-1];
      logic [P-1:0]     leaf;
      node = '{default: '0};
      leaf = '0;
      for (int unsigned e = 0; e < INPUTS_AMOUNT; e++) begin
         leaf = data_i[e*P +: P];
         node[INPUTS_AMOUNT-1+e] = signed_i ? SUM_W'(signed'(leaf)) : SUM_W'(leaf);
      end
      for (int unsigned k = 0; k < INPUTS_AMOUNT-1; k++) begin
         node[INPUTS_AMOUNT-2-k] = node[2*(INPUTS_AMOUNT-2-k)+1] + node[2*(INPUTS_AMOUNT-2-k)+2];
      end
      sum_o = node[0];
   end

endmodule

// File: rtl/binary_tree_adder_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer, wrapping.
module rr_arbiter
   import binary_tree_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_idx_o,
   output logic               gnt_valid_o
);

   always_comb begin
      int unsigned idx;
      logic        found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_i) + k) % 32'(NUM_REQ);
         if (!found && (|(req_i & (NUM_REQ'(1) << idx)))) begin
            found     = 1'b1;
            gnt_o     = NUM_REQ'(1) << idx;
            gnt_idx_o = ID_W'(idx);
         end
      end
      gnt_valid_o = found;
   end

endmodule

// File: rtl/binary_tree_adder_scheduler.sv
// Shares one binary tree adder among NUM_REQ requesters; each granted reduction is
// accumulated over its beats and returned with owner id and saturating beat count.
module binary_tree_adder_scheduler
   import binary_tree_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int INPUTS_AMOUNT = 8,
   parameter int P             = 8,
   parameter int ACC_W         = 32,
   parameter int BEAT_W        = 8,
   localparam int ID_W         = id_width(NUM_REQ)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 in_valid_i,
   output logic [NUM_REQ-1:0]                 in_ready_o,
   input  logic [NUM_REQ*INPUTS_AMOUNT*P-1:0] in_data_i,
   input  logic [NUM_REQ-1:0]                 in_last_i,
   input  logic [NUM_REQ-1:0]                 in_signed_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [ACC_W-1:0]                   out_sum_o,
   output logic [ID_W-1:0]                    out_id_o,
   output logic [BEAT_W-1:0]                  out_beats_o
);

   localparam int W     = INPUTS_AMOUNT * P;
   localparam int SUM_W = tree_sum_width(P, INPUTS_AMOUNT);

   sched_state_e        state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d;
   logic                sgn_q, sgn_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [BEAT_W-1:0]   beats_q, beats_d;

   logic [NUM_REQ-1:0]  gnt, sel_mask, ready;
   logic [ID_W-1:0]     gnt_idx, sel_id;
   logic                gnt_valid, sel_valid, sel_last, sel_sgn;
   logic [W-1:0]        beat_data;
   logic [SUM_W-1:0]    tree_sum;
   logic [ACC_W-1:0]    beat_ext;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i       (in_valid_i),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // The adder input follows the live grant in IDLE and the locked owner afterwards.
   assign sel_id    = (state_q == IDLE) ? gnt_idx : id_q;
   assign sel_mask  = NUM_REQ'(1) << sel_id;
   assign sel_valid = |(in_valid_i & sel_mask);
   assign sel_last  = |(in_last_i & sel_mask);
   assign sel_sgn   = (state_q == IDLE) ? (|(in_signed_i & sel_mask)) : sgn_q;
   assign beat_data = W'(in_data_i >> (32'(sel_id) * 32'(W)));

   binary_tree_adder #(
      .INPUTS_AMOUNT (INPUTS_AMOUNT),
      .P             (P),
      .MODE          (1)
   ) u_tree (
      .data_i   (beat_data),
      .signed_i (sel_sgn),
      .sum_o    (tree_sum)
   );

   assign beat_ext = sel_sgn ? ACC_W'(signed'(tree_sum)) : ACC_W'(tree_sum);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      sgn_d   = sgn_q;
      acc_d   = acc_q;
      beats_d = beats_q;
      ready   = '0;
      case (state_q)
         IDLE: begin
            ready = gnt;
            if (gnt_valid) begin
               id_d    = gnt_idx;
               sgn_d   = sel_sgn;
               acc_d   = beat_ext;
               beats_d = BEAT_W'(1);
               ptr_d   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
               state_d = sel_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            ready = sel_mask;
            if (sel_valid) begin
               acc_d   = acc_q + beat_ext;
               beats_d = (&beats_q) ? beats_q : beats_q + BEAT_W'(1);
               if (sel_last) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         sgn_q   <= 1'b0;
         acc_q   <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         sgn_q   <= sgn_d;
         acc_q   <= acc_d;
         beats_q <= beats_d;
      end
   end

   // No beat is reported as accepted while reset is being applied.
   assign in_ready_o  = rst_i ? '0 : ready;
   assign out_valid_o = (state_q == DONE);
   assign out_sum_o   = acc_q;
   assign out_id_o    = id_q;
   assign out_beats_o = beats_q;

endmodule

// File: tb/tb_binary_tree_adder_scheduler.sv
// Directed bench for binary_tree_adder_scheduler with a per-cycle reference model.
module tb_binary_tree_adder_scheduler;

   localparam int NR     = 4;
   localparam int IA     = 8;
   localparam int P      = 8;
   localparam int ACC_W  = 32;
   localparam int BEAT_W = 8;
   localparam int IDW    = 2;

   logic                  clk = 1'b0;
   logic                  rst_i;
   logic [NR-1:0]         in_valid_i;
   logic [NR-1:0]         in_ready_o;
   logic [NR*IA*P-1:0]    in_data_i;
   logic [NR-1:0]         in_last_i;
   logic [NR-1:0]         in_signed_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [ACC_W-1:0]      out_sum_o;
   logic [IDW-1:0]        out_id_o;
   logic [BEAT_W-1:0]     out_beats_o;

   int checks = 0;
   int errors = 0;

   binary_tree_adder_scheduler #(
      .NUM_REQ       (NR),
      .INPUTS_AMOUNT (IA),
      .P             (P),
      .ACC_W         (ACC_W),
      .BEAT_W        (BEAT_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_signed_i (in_signed_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_sum_o   (out_sum_o),
      .out_id_o    (out_id_o),
      .out_beats_o (out_beats_o)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the adder, running integer sum, beat count, result pending.
   int     m_owner = -1;
   bit     m_done  = 1'b0;
   longint m_acc   = 0;
   int     m_beats = 0;
   bit     m_sgn   = 1'b0;
   int     m_ptr   = 0;
   int     grant_log[$];
   int     res_id[$];
   longint res_sum[$];

   function automatic logic [NR-1:0] model_mask();
      logic [NR-1:0] m;
      m = '0;
      if (m_done) return m;
      if (m_owner >= 0) begin
         m[m_owner] = 1'b1;
         return m;
      end
      for (int k = 0; k < NR; k++) begin
         if (in_valid_i[(m_ptr + k) % NR]) begin
            m[(m_ptr + k) % NR] = 1'b1;
            return m;
         end
      end
      return m;
   endfunction

   function automatic longint beat_value(int r, bit s);
      longint     total;
      logic [7:0] b;
      total = 0;
      for (int e = 0; e < IA; e++) begin
         b = in_data_i[(r*IA+e)*P +: P];
         total += s ? longint'($signed(b)) : longint'(b);
      end
      return total;
   endfunction

   always @(posedge clk) begin
      logic [NR-1:0] m;
      if (rst_i) begin
         m_owner = -1; m_done = 1'b0; m_acc = 0; m_beats = 0; m_sgn = 1'b0; m_ptr = 0;
      end else if (m_done) begin
         if (out_ready_i) begin
            res_id.push_back(m_owner);
            res_sum.push_back(m_acc);
            m_done  = 1'b0;
            m_owner = -1;
         end
      end else begin
         m = model_mask();
         for (int r = 0; r < NR; r++) begin
            if (m[r] && in_valid_i[r]) begin
               if (m_owner < 0) begin
                  m_owner = r; m_sgn = in_signed_i[r]; m_acc = 0; m_beats = 0;
                  m_ptr   = (r + 1) % NR;
                  grant_log.push_back(r);
               end
               m_acc += beat_value(r, m_sgn);
               if (m_beats < 255) m_beats++;
               if (in_last_i[r]) m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NR-1:0] er;
      er = rst_i ? '0 : model_mask();
      checks++;
      if (in_ready_o !== er) begin
         errors++;
         $display("FAIL model_ready got %b exp %b at %0t", in_ready_o, er, $time);
      end
      checks++;
      if (out_valid_o !== m_done) begin
         errors++;
         $display("FAIL model_valid got %b exp %b at %0t", out_valid_o, m_done, $time);
      end
      if (m_done) begin
         checks++;
         if (out_sum_o !== m_acc[31:0] || out_id_o !== IDW'(m_owner) || out_beats_o !== BEAT_W'(m_beats)) begin
            errors++;
            $display("FAIL model_result got sum %h id %0d beats %0d exp sum %h id %0d beats %0d",
                     out_sum_o, out_id_o, out_beats_o, m_acc[31:0], m_owner, m_beats);
         end
      end
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic send_beat(input int r, input logic [7:0] val, input bit last, input bit sgn);
      bit got;
      in_valid_i[r]  = 1'b1;
      in_last_i[r]   = last;
      in_signed_i[r] = sgn;
      for (int e = 0; e < IA; e++) in_data_i[(r*IA+e)*P +: P] = val;
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge clk);
         got = in_ready_o[r];
         @(posedge clk);
         #1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout requester %0d got no ready exp ready", r);
      end
      in_valid_i[r] = 1'b0;
      in_last_i[r]  = 1'b0;
   endtask

   task automatic wait_result(input string name, input longint sum, input int id, input int beats,
                              input bit chk_latency);
      int c;
      c = 0;
      @(negedge clk);
      while (!out_valid_o && c < 1000) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_valid"}, out_valid_o, 1);
      chk({name, "_sum"},   out_sum_o,   sum);
      chk({name, "_id"},    out_id_o,    id);
      chk({name, "_beats"}, out_beats_o, beats);
      if (chk_latency) chk({name, "_latency"}, c, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_i      = 1'b1;
      in_valid_i = '0;
      in_last_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst_i       = 1'b1;
      in_valid_i  = '0;
      in_last_i   = '0;
      in_signed_i = '0;
      in_data_i   = '0;
      out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", in_ready_o, 0);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_sum",   out_sum_o,   0);
      chk("rst_id",    out_id_o,    0);
      chk("rst_beats", out_beats_o, 0);
      #1;
      rst_i = 1'b0;
      @(posedge clk);
      #1;

      // 1: single unsigned beat of 0xFF
      send_beat(0, 8'hFF, 1'b1, 1'b1 ^ 1'b1);
      wait_result("t1", 2040, 0, 1, 1'b1);

      // 2: three signed -1 beats; signed flag flips on later beats and must be ignored
      send_beat(2, 8'hFF, 1'b0, 1'b1);
      send_beat(2, 8'hFF, 1'b0, 1'b0);
      send_beat(2, 8'hFF, 1'b1, 1'b0);
      wait_result("t2", 64'h0000_0000_FFFF_FFE8, 2, 3, 1'b1);

      // 3: simultaneous requesters 0,1,3 from pointer 0
      apply_reset();
      grant_log.delete();
      res_id.delete();
      res_sum.delete();
      fork
         begin
            send_beat(0, 8'd1, 1'b0, 1'b0);
            send_beat(0, 8'd1, 1'b1, 1'b0);
         end
         send_beat(1, 8'd2, 1'b1, 1'b0);
         send_beat(3, 8'd3, 1'b1, 1'b0);
         begin
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (grant_log.size() > 0) break;
            end
            chk("t3_lock_ready", in_ready_o, 4'b0001);
         end
      join
      c = 0;
      while (res_id.size() < 3 && c < 50) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("t3_grants", grant_log.size(), 3);
      chk("t3_results", res_id.size(), 3);
      if (grant_log.size() >= 3 && res_id.size() >= 3) begin
         chk("t3_g0", grant_log[0], 0);
         chk("t3_g1", grant_log[1], 1);
         chk("t3_g2", grant_log[2], 3);
         chk("t3_s0", res_sum[0], 16);
         chk("t3_s1", res_sum[1], 16);
         chk("t3_s2", res_sum[2], 24);
      end

      // 4: consumer stalls five cycles in DONE while another requester waits
      out_ready_i = 1'b0;
      send_beat(1, 8'd3, 1'b1, 1'b0);
      in_valid_i[2] = 1'b1;
      in_last_i[2]  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t4_valid", out_valid_o, 1);
         chk("t4_sum",   out_sum_o,   24);
         chk("t4_id",    out_id_o,    1);
         chk("t4_beats", out_beats_o, 1);
         chk("t4_ready", in_ready_o,  0);
      end
      #1;
      out_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t4_exit_valid", out_valid_o, 0);
      chk("t4_idle_grant", in_ready_o, 4'b0100);
      #1;
      in_valid_i[2] = 1'b0;
      in_last_i[2]  = 1'b0;
      @(posedge clk);
      #1;

      // 5: reset in the middle of an accumulation
      send_beat(3, 8'd1, 1'b0, 1'b0);
      send_beat(3, 8'd1, 1'b0, 1'b0);
      rst_i = 1'b1;
      @(negedge clk);
      chk("t5_rst_ready", in_ready_o, 0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("t5_valid", out_valid_o, 0);
      chk("t5_sum",   out_sum_o,   0);
      chk("t5_id",    out_id_o,    0);
      chk("t5_beats", out_beats_o, 0);
      chk("t5_ready", in_ready_o,  0);
      @(posedge clk);
      #1;
      send_beat(0, 8'd2, 1'b1, 1'b0);
      wait_result("t5_new", 16, 0, 1, 1'b1);

      // 6: beat counter saturation over 300 zero beats
      for (int b = 0; b < 300; b++) send_beat(1, 8'd0, (b == 299), 1'b0);
      wait_result("t6", 0, 1, 255, 1'b1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
